// File: rtl/perspective_pixel_map_pkg.sv
// Shared widths, frame limits and FSM state encoding for the perspective pixel mapper.
package perspective_pixel_map_pkg;

  // Inverse-parameter widths as delivered by the parameter block
  localparam int unsigned P1_W = 68;
  localparam int unsigned P2_W = 69;
  localparam int unsigned P3_W = 79;
  localparam int unsigned P4_W = 68;
  localparam int unsigned P5_W = 69;
  localparam int unsigned P6_W = 79;
  localparam int unsigned P7_W = 59;
  localparam int unsigned P8_W = 60;
  localparam int unsigned P9_W = 71;

  // Full-precision numerator / denominator widths
  localparam int unsigned NUM_W = 82;
  localparam int unsigned DEN_W = 73;

  // Quotient bits (one divider iteration per bit) and pixel coordinate widths
  localparam int unsigned QBITS = 10;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;

  // Source frame extent
  localparam int unsigned SRC_W = 640;
  localparam int unsigned SRC_H = 480;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_CHECK = 3'd2,
    S_DIV   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/perspective_pixel_map_if.sv
// Pixel request / source-coordinate response handshake bundle.
interface perspective_pixel_map_if;
  import perspective_pixel_map_pkg::*;

  logic           req_valid;
  logic           req_ready;
  logic [X_W-1:0] req_x;
  logic [Y_W-1:0] req_y;
  logic           resp_valid;
  logic           resp_ready;
  logic [X_W-1:0] src_x;
  logic [Y_W-1:0] src_y;
  logic           src_oob;

  // Requester side (display pipeline)
  modport master (
    output req_valid, req_x, req_y, resp_ready,
    input  req_ready, resp_valid, src_x, src_y, src_oob
  );

  // Mapper side
  modport slave (
    input  req_valid, req_x, req_y, resp_ready,
    output req_ready, resp_valid, src_x, src_y, src_oob
  );

endinterface

// File: rtl/perspective_pixel_map_div.sv
// Unsigned sequential restoring divider, MSB-first, one quotient bit per cycle.
// The caller guarantees num_i < den_i << QBITS so the quotient fits in QBITS bits.
// done_c is high during the final iteration; quo_c then carries the finished quotient.
module perspective_pixel_map_div #(
  parameter int unsigned NUM_W = 82,
  parameter int unsigned DEN_W = 73,
  parameter int unsigned QBITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_c,
  output logic [QBITS-1:0] quo_c
);

  localparam int unsigned CW = $clog2(QBITS + 1);
  localparam int unsigned WW = NUM_W + 2;

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] dsr_q, dsr_d;
  logic [QBITS-1:0] quo_q, quo_d;
  logic [CW-1:0]    k;
  logic [WW-1:0]    trial;
  logic             ge;

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      quo_q  <= quo_d;
    end
  end

  // One restoring step: subtract den << k when it fits, set quotient bit k
  always_comb begin
    k      = cnt_q - CW'(1);
    trial  = WW'(dsr_q) << k;
    ge     = WW'(rem_q) >= trial;
    quo_c  = quo_q | (ge ? (QBITS'(1) << k) : '0);
    done_c = busy_q && (cnt_q == CW'(1));
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    quo_d  = quo_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CW'(QBITS);
      rem_d  = num_i;
      dsr_d  = den_i;
      quo_d  = '0;
    end else if (busy_q) begin
      rem_d  = ge ? NUM_W'(WW'(rem_q) - trial) : rem_q;
      quo_d  = quo_c;
      cnt_d  = k;
      busy_d = !done_c;
    end
  end

endmodule

// File: rtl/perspective_pixel_map.sv
// Maps a display pixel (X,Y) to its source-frame pixel through the inverse
// perspective transform, flagging results that fall outside the source frame.
module perspective_pixel_map
  import perspective_pixel_map_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [P1_W-1:0] p1_inv,
  input  logic signed [P2_W-1:0] p2_inv,
  input  logic signed [P3_W-1:0] p3_inv,
  input  logic signed [P4_W-1:0] p4_inv,
  input  logic signed [P5_W-1:0] p5_inv,
  input  logic signed [P6_W-1:0] p6_inv,
  input  logic signed [P7_W-1:0] p7_inv,
  input  logic signed [P8_W-1:0] p8_inv,
  input  logic signed [P9_W-1:0] p9_inv,
  input  logic                   params_load,
  perspective_pixel_map_if.slave bus
);

  localparam int unsigned LW = NUM_W + 2;

  state_e                   state_q, state_d;
  logic signed [P1_W-1:0]   p1_q, p1_d;
  logic signed [P2_W-1:0]   p2_q, p2_d;
  logic signed [P3_W-1:0]   p3_q, p3_d;
  logic signed [P4_W-1:0]   p4_q, p4_d;
  logic signed [P5_W-1:0]   p5_q, p5_d;
  logic signed [P6_W-1:0]   p6_q, p6_d;
  logic signed [P7_W-1:0]   p7_q, p7_d;
  logic signed [P8_W-1:0]   p8_q, p8_d;
  logic signed [P9_W-1:0]   p9_q, p9_d;
  logic [X_W-1:0]           x_q, x_d;
  logic [Y_W-1:0]           y_q, y_d;
  logic signed [NUM_W-1:0]  num_x_q, num_x_d, num_y_q, num_y_d;
  logic signed [DEN_W-1:0]  den_q, den_d;
  logic                     load_pend_q, load_pend_d;
  logic                     req_ready_q, req_ready_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [X_W-1:0]           src_x_q, src_x_d;
  logic [Y_W-1:0]           src_y_q, src_y_d;
  logic                     src_oob_q, src_oob_d;

  logic signed [NUM_W-1:0]  xn, yn, mac_nx, mac_ny;
  logic signed [DEN_W-1:0]  xd, yd, mac_den;
  logic                     nx_neg, ny_neg, d_neg;
  logic [NUM_W-1:0]         mag_nx, mag_ny;
  logic [DEN_W-1:0]         mag_d;
  logic [LW-1:0]            lim;
  logic                     oob_x, oob_y, early_oob, range_oob;
  logic                     div_start;
  logic                     done_x, done_y;
  logic [QBITS-1:0]         qx, qy;

  // Full-width products; coordinates are zero-extended into the signed domain
  always_comb begin
    xn      = NUM_W'($signed({1'b0, x_q}));
    yn      = NUM_W'($signed({1'b0, y_q}));
    xd      = DEN_W'($signed({1'b0, x_q}));
    yd      = DEN_W'($signed({1'b0, y_q}));
    mac_nx  = NUM_W'(p1_q) * xn + NUM_W'(p2_q) * yn + NUM_W'(p3_q);
    mac_ny  = NUM_W'(p4_q) * xn + NUM_W'(p5_q) * yn + NUM_W'(p6_q);
    mac_den = DEN_W'(p7_q) * xd + DEN_W'(p8_q) * yd + DEN_W'(p9_q);
  end

  // Sign/magnitude split and early out-of-bounds detection (zero den, negative quotient, overflow)
  always_comb begin
    nx_neg    = num_x_q[NUM_W-1];
    ny_neg    = num_y_q[NUM_W-1];
    d_neg     = den_q[DEN_W-1];
    mag_nx    = nx_neg ? -num_x_q : num_x_q;
    mag_ny    = ny_neg ? -num_y_q : num_y_q;
    mag_d     = d_neg ? -den_q : den_q;
    lim       = LW'(mag_d) << QBITS;
    oob_x     = (den_q == '0) || ((num_x_q != '0) && (nx_neg != d_neg)) || (LW'(mag_nx) >= lim);
    oob_y     = (den_q == '0) || ((num_y_q != '0) && (ny_neg != d_neg)) || (LW'(mag_ny) >= lim);
    early_oob = oob_x || oob_y;
    range_oob = (qx >= QBITS'(SRC_W)) || (qy >= QBITS'(SRC_H));
  end

  perspective_pixel_map_div #(.NUM_W(NUM_W), .DEN_W(DEN_W), .QBITS(QBITS)) u_div_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (div_start),
    .num_i   (mag_nx),
    .den_i   (mag_d),
    .done_c  (done_x),
    .quo_c   (qx)
  );

  perspective_pixel_map_div #(.NUM_W(NUM_W), .DEN_W(DEN_W), .QBITS(QBITS)) u_div_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (div_start),
    .num_i   (mag_ny),
    .den_i   (mag_d),
    .done_c  (done_y),
    .quo_c   (qy)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      p1_q         <= '0;
      p2_q         <= '0;
      p3_q         <= '0;
      p4_q         <= '0;
      p5_q         <= '0;
      p6_q         <= '0;
      p7_q         <= '0;
      p8_q         <= '0;
      p9_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      num_x_q      <= '0;
      num_y_q      <= '0;
      den_q        <= '0;
      load_pend_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      src_x_q      <= '0;
      src_y_q      <= '0;
      src_oob_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      p3_q         <= p3_d;
      p4_q         <= p4_d;
      p5_q         <= p5_d;
      p6_q         <= p6_d;
      p7_q         <= p7_d;
      p8_q         <= p8_d;
      p9_q         <= p9_d;
      x_q          <= x_d;
      y_q          <= y_d;
      num_x_q      <= num_x_d;
      num_y_q      <= num_y_d;
      den_q        <= den_d;
      load_pend_q  <= load_pend_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      src_x_q      <= src_x_d;
      src_y_q      <= src_y_d;
      src_oob_q    <= src_oob_d;
    end
  end

  // Next-state, parameter capture and registered-output logic
  always_comb begin
    state_d     = state_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;
    p4_d        = p4_q;
    p5_d        = p5_q;
    p6_d        = p6_q;
    p7_d        = p7_q;
    p8_d        = p8_q;
    p9_d        = p9_q;
    x_d         = x_q;
    y_d         = y_q;
    num_x_d     = num_x_q;
    num_y_d     = num_y_q;
    den_d       = den_q;
    load_pend_d = load_pend_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    src_oob_d   = src_oob_q;
    div_start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A load (new or deferred) lands here, before any same-cycle request is processed
        if (params_load || load_pend_q) begin
          p1_d        = p1_inv;
          p2_d        = p2_inv;
          p3_d        = p3_inv;
          p4_d        = p4_inv;
          p5_d        = p5_inv;
          p6_d        = p6_inv;
          p7_d        = p7_inv;
          p8_d        = p8_inv;
          p9_d        = p9_inv;
          load_pend_d = 1'b0;
        end
        if (bus.req_valid && req_ready_q) begin
          x_d     = bus.req_x;
          y_d     = bus.req_y;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        num_x_d = mac_nx;
        num_y_d = mac_ny;
        den_d   = mac_den;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (early_oob) begin
          src_oob_d = 1'b1;
          src_x_d   = '0;
          src_y_d   = '0;
          state_d   = S_DONE;
        end else begin
          div_start = 1'b1;
          state_d   = S_DIV;
        end
      end
      S_DIV: begin
        if (done_x && done_y) begin
          if (range_oob) begin
            src_oob_d = 1'b1;
            src_x_d   = '0;
            src_y_d   = '0;
          end else begin
            src_oob_d = 1'b0;
            src_x_d   = X_W'(qx);
            src_y_d   = qy[Y_W-1:0];
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Loads arriving mid-transaction wait for the next idle cycle
    if ((state_q != S_IDLE) && params_load) load_pend_d = 1'b1;

    resp_valid_d = (state_d == S_DONE);
    req_ready_d  = (state_d == S_IDLE) && !load_pend_d;
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.src_x      = src_x_q;
  assign bus.src_y      = src_y_q;
  assign bus.src_oob    = src_oob_q;

endmodule

// File: tb/tb_perspective_pixel_map.sv
// Directed bench for perspective_pixel_map with hand-computed expected coordinates.
module tb_perspective_pixel_map;
  import perspective_pixel_map_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [P1_W-1:0] p1_inv;
  logic signed [P2_W-1:0] p2_inv;
  logic signed [P3_W-1:0] p3_inv;
  logic signed [P4_W-1:0] p4_inv;
  logic signed [P5_W-1:0] p5_inv;
  logic signed [P6_W-1:0] p6_inv;
  logic signed [P7_W-1:0] p7_inv;
  logic signed [P8_W-1:0] p8_inv;
  logic signed [P9_W-1:0] p9_inv;
  logic params_load;

  int n_chk;
  int n_bad;
  int lat;

  perspective_pixel_map_if bus();

  perspective_pixel_map dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p1_inv      (p1_inv),
    .p2_inv      (p2_inv),
    .p3_inv      (p3_inv),
    .p4_inv      (p4_inv),
    .p5_inv      (p5_inv),
    .p6_inv      (p6_inv),
    .p7_inv      (p7_inv),
    .p8_inv      (p8_inv),
    .p9_inv      (p9_inv),
    .params_load (params_load),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_params(input longint v1, input longint v2, input longint v3,
                            input longint v4, input longint v5, input longint v6,
                            input longint v7, input longint v8, input longint v9);
    p1_inv = P1_W'(v1);
    p2_inv = P2_W'(v2);
    p3_inv = P3_W'(v3);
    p4_inv = P4_W'(v4);
    p5_inv = P5_W'(v5);
    p6_inv = P6_W'(v6);
    p7_inv = P7_W'(v7);
    p8_inv = P8_W'(v8);
    p9_inv = P9_W'(v9);
  endtask

  task automatic load_params(input longint v1, input longint v2, input longint v3,
                             input longint v4, input longint v5, input longint v6,
                             input longint v7, input longint v8, input longint v9);
    set_params(v1, v2, v3, v4, v5, v6, v7, v8, v9);
    params_load = 1'b1;
    @(posedge clk); #1;
    params_load = 1'b0;
  endtask

  // Present one request and return just after the accepting edge (cycle 1)
  task automatic send_req(input int x, input int y);
    int g = 0;
    while (!bus.req_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_x     = X_W'(x);
    bus.req_y     = Y_W'(y);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    check("busy_ready", 32'(bus.req_ready), 32'd0);
  endtask

  // Wait for the response, check it, optionally stall, then complete the handshake
  task automatic wait_resp(input string tag, input int ex, input int ey, input int eo,
                           input int elat, input int hold);
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), elat);
    check({tag, "_x"}, 32'(bus.src_x), ex);
    check({tag, "_y"}, 32'(bus.src_y), ey);
    check({tag, "_oob"}, 32'(bus.src_oob), eo);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, "_hold_x"}, 32'(bus.src_x), ex);
      check({tag, "_hold_y"}, 32'(bus.src_y), ey);
      check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({tag, "_drop"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    n_chk          = 0;
    n_bad          = 0;
    lat            = 0;
    rst_n          = 1'b0;
    params_load    = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.resp_ready = 1'b0;
    set_params(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_src_x", 32'(bus.src_x), 32'd0);
    check("rst_src_y", 32'(bus.src_y), 32'd0);
    check("rst_src_oob", 32'(bus.src_oob), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity and frame corner
    load_params(1, 0, 0, 0, 1, 0, 0, 0, 1);
    send_req(100, 50);  wait_resp("ident", 100, 50, 0, 13, 0);
    send_req(639, 479); wait_resp("corner", 639, 479, 0, 13, 0);
    load_params(1, 0, 1, 0, 1, 0, 0, 0, 1);
    send_req(639, 479); wait_resp("corner_oob", 0, 0, 1, 13, 0);

    // Scale by one half (truncating)
    load_params(1, 0, 0, 0, 1, 0, 0, 0, 2);
    send_req(101, 51);  wait_resp("scale", 50, 25, 0, 13, 0);

    // Translate: negative numerator exits early, positive maps through
    load_params(1, 0, -200, 0, 1, 0, 0, 0, 1);
    send_req(100, 10);  wait_resp("trans_neg", 0, 0, 1, 3, 0);
    send_req(300, 10);  wait_resp("trans", 100, 10, 0, 13, 0);

    // Zero and negative denominators
    load_params(0, 0, 0, 0, 0, 0, 0, 0, 0);
    send_req(33, 44);   wait_resp("zero_den", 0, 0, 1, 3, 0);
    load_params(-1, 0, 0, 0, -1, 0, 0, 0, -1);
    send_req(7, 9);     wait_resp("neg_den", 7, 9, 0, 13, 0);

    // Quotient overflow boundary: 1200 >= 1024 exits early, 1022 divides then fails range
    load_params(2, 0, 0, 0, 1, 0, 0, 0, 1);
    send_req(600, 5);   wait_resp("ovf", 0, 0, 1, 3, 0);
    send_req(511, 5);   wait_resp("big_q", 0, 0, 1, 13, 0);

    // Mixed terms: x=(3*100+50+5)/4=88, y=(2*50-1)/4=24
    load_params(3, 1, 5, 0, 2, -1, 0, 0, 4);
    send_req(100, 50);  wait_resp("mix", 88, 24, 0, 13, 0);

    // Projective denominator: den=9+20+1=30, x=900/30, y=1200/30
    load_params(100, 0, 0, 0, 60, 0, 1, 1, 1);
    send_req(9, 20);    wait_resp("persp", 30, 40, 0, 13, 0);

    // Wide constants: 2^62/2^56=64, 3*2^56/2^56=3
    load_params(0, 0, longint'(1) << 62, 0, 0, longint'(3) << 56, 0, 0, longint'(1) << 56);
    send_req(0, 0);     wait_resp("wide", 64, 3, 0, 13, 0);

    // Back-pressure: response held for 5 cycles
    load_params(1, 0, 0, 0, 1, 0, 0, 0, 1);
    send_req(5, 6);     wait_resp("hold", 5, 6, 0, 13, 5);

    // Load during DIV: in-flight pixel keeps old params, capture costs one idle cycle
    send_req(100, 50);
    repeat (5) begin
      @(posedge clk); #1;
      lat++;
    end
    set_params(1, 0, 0, 0, 1, 0, 0, 0, 2);
    params_load = 1'b1;
    @(posedge clk); #1;
    params_load = 1'b0;
    lat++;
    wait_resp("midload", 100, 50, 0, 13, 0);
    check("pend_ready", 32'(bus.req_ready), 32'd0);
    send_req(101, 51);  wait_resp("after_load", 50, 25, 0, 13, 0);

    // Asynchronous reset during DIV
    load_params(1, 0, 0, 0, 1, 0, 0, 0, 1);
    send_req(100, 50);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_req_ready", 32'(bus.req_ready), 32'd1);
    check("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("arst_src_x", 32'(bus.src_x), 32'd0);
    check("arst_src_y", 32'(bus.src_y), 32'd0);
    check("arst_src_oob", 32'(bus.src_oob), 32'd0);
    #2 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("arst_no_resp", 32'(bus.resp_valid), 32'd0);
    // Working params were cleared, so the denominator is zero
    send_req(1, 1);     wait_resp("post_rst_zero", 0, 0, 1, 3, 0);
    load_params(1, 0, 0, 0, 1, 0, 0, 0, 1);
    send_req(100, 50);  wait_resp("post_rst", 100, 50, 0, 13, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
